// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM/engine types and the engine shift-width helper
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, REDUCE, DONE} state_t;
  typedef enum logic [2:0] {ST_U_ZERO, ST_V_ZERO, ST_BOTH_EVEN, ST_U_EVEN, ST_V_EVEN, ST_SUB_U, ST_SUB_V} step_t;
  function automatic int shift_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/gcd_stein_core.sv
// gcd_stein_core: binary (Stein) GCD of two operands, one step per clock, done pulses with result
module gcd_stein_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int KW = shift_w(WIDTH);
  logic [WIDTH-1:0] u, v;
  logic [KW-1:0] k;
  logic active;
  step_t step;
  always_comb
    step = u == '0 ? ST_U_ZERO :
           v == '0 ? ST_V_ZERO :
           (!u[0] && !v[0]) ? ST_BOTH_EVEN :
           !u[0] ? ST_U_EVEN :
           !v[0] ? ST_V_EVEN :
           u >= v ? ST_SUB_U : ST_SUB_V;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      u <= '0;
      v <= '0;
      k <= '0;
      active <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (clr) active <= 1'b0;
      else if (start) begin
        u <= a;
        v <= b;
        k <= '0;
        active <= 1'b1;
      end else if (active) begin
        unique case (step)
          ST_U_ZERO: begin result <= v << k; done <= 1'b1; active <= 1'b0; end
          ST_V_ZERO: begin result <= u << k; done <= 1'b1; active <= 1'b0; end
          ST_BOTH_EVEN: begin u <= u >> 1; v <= v >> 1; k <= k + KW'(1); end
          ST_U_EVEN: u <= u >> 1;
          ST_V_EVEN: v <= v >> 1;
          ST_SUB_U: u <= u - v;
          ST_SUB_V: v <= v - u;
          default: active <= 1'b0;
        endcase
      end
    end
endmodule

// File: rtl/gcd_nway.sv
// gcd_nway: streaming GCD of N_OPERANDS operands; define GCD_EARLY_EXIT_EN to bypass the engine once acc reaches 1
module gcd_nway
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_OPERANDS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             busy
);
  localparam int CNT_W = $clog2(N_OPERANDS + 1);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N_OPERANDS);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, eng_result;
  logic [CNT_W-1:0] count;
  logic in_fire, eng_start, eng_done, skip;
`ifdef GCD_EARLY_EXIT_EN
  assign skip = acc == WIDTH'(1);
`else
  assign skip = 1'b0;
`endif
  assign in_ready = state == IDLE || state == FETCH;
  assign out_valid = state == DONE;
  assign out_gcd = state == DONE ? acc : '0;
  assign busy = state != IDLE;
  assign in_fire = in_valid && in_ready;
  assign eng_start = state == FETCH && in_fire && !skip && !abort;
  gcd_stein_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .reset(reset),
    .clr(abort),
    .start(eng_start),
    .a(acc),
    .b(in_data),
    .done(eng_done),
    .result(eng_result)
  );
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else
      case (state)
        IDLE: state_n = in_fire ? FETCH : IDLE;
        FETCH: state_n = !in_fire ? FETCH : !skip ? REDUCE : count == N_C - CNT_W'(1) ? DONE : FETCH;
        REDUCE: state_n = !eng_done ? REDUCE : count == N_C ? DONE : FETCH;
        DONE: state_n = out_ready ? IDLE : DONE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      count <= '0;
    end else if (abort || (state == DONE && out_ready)) begin
      acc <= '0;
      count <= '0;
    end else if (state == IDLE && in_fire) begin
      acc <= in_data;
      count <= CNT_W'(1);
    end else if (state == FETCH && in_fire) count <= count + CNT_W'(1);
    else if (state == REDUCE && eng_done) acc <= eng_result;
endmodule
